// File: rtl/bram_tdp_arbiter.sv
// Round-robin arbiter sharing one read-first true-dual-port BRAM among NREQ requesters.
// Define BRAM_ARB_STATS_EN to add the saturating stat_grants / stat_conflicts counters.
module bram_tdp_arbiter #(
  parameter int NREQ  = 4,
  parameter int SIZE  = 1024,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(SIZE),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*WIDTH-1:0] rsp_rdata,
  output logic                  ena,
  output logic                  enb,
  output logic                  wea,
  output logic                  web,
  output logic [AW-1:0]         addra,
  output logic [AW-1:0]         addrb,
  output logic [WIDTH-1:0]      dia,
  output logic [WIDTH-1:0]      dib,
  input  logic [WIDTH-1:0]      doa,
  input  logic [WIDTH-1:0]      dob
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grants,
  output logic [31:0]           stat_conflicts
`endif
);

  // Handshake: a request transfers in the cycle req_valid[i] && req_ready[i];
  // requesters hold we/addr/wdata stable until then. Responses are one-cycle
  // pulses exactly one cycle after the grant, with no backpressure.

  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= NREQ) ? PW'(v - NREQ) : PW'(v);
  endfunction

  logic [PW-1:0]    rr_ptr;
  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  logic             a_found, b_found, conflict;
  logic [PW-1:0]    a_idx, b_idx, cand;
  int               a_pos;
  logic             gnt_a, gnt_b;
  logic [PW-1:0]    last_idx, nxt_ptr;

  logic             own_a_vld, own_b_vld;
  logic [PW-1:0]    own_a_idx, own_b_idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*AW +: AW];
      wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
    end
  end

  // Port B scans only the remainder of the rotation after A, so a requester
  // can never win both ports and the pointer window is never wrapped twice.
  always_comb begin
    a_found  = 1'b0;
    a_idx    = '0;
    a_pos    = 0;
    b_found  = 1'b0;
    b_idx    = '0;
    conflict = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap(int'(rr_ptr) + k);
      if (!a_found && req_valid[cand]) begin
        a_found = 1'b1;
        a_idx   = cand;
        a_pos   = k;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap(int'(rr_ptr) + k);
      if (a_found && !b_found && (k > a_pos) && req_valid[cand]) begin
        if ((addr_arr[cand] == addr_arr[a_idx]) && (req_we[cand] || req_we[a_idx])) begin
          conflict = 1'b1;
        end else begin
          b_found = 1'b1;
          b_idx   = cand;
        end
      end
    end
  end

  assign gnt_a    = a_found & ~rst;
  assign gnt_b    = b_found & ~rst;
  assign last_idx = gnt_b ? b_idx : a_idx;
  assign nxt_ptr  = wrap(int'(last_idx) + 1);

  assign ena   = gnt_a;
  assign enb   = gnt_b;
  assign wea   = gnt_a & req_we[a_idx];
  assign web   = gnt_b & req_we[b_idx];
  assign addra = gnt_a ? addr_arr[a_idx]  : '0;
  assign addrb = gnt_b ? addr_arr[b_idx]  : '0;
  assign dia   = gnt_a ? wdata_arr[a_idx] : '0;
  assign dib   = gnt_b ? wdata_arr[b_idx] : '0;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (gnt_a && (a_idx == PW'(i))) || (gnt_b && (b_idx == PW'(i)));
      if (!rst && own_a_vld && (own_a_idx == PW'(i))) begin
        rsp_valid[i]                = 1'b1;
        rsp_rdata[i*WIDTH +: WIDTH] = doa;
      end
      if (!rst && own_b_vld && (own_b_idx == PW'(i))) begin
        rsp_valid[i]                = 1'b1;
        rsp_rdata[i*WIDTH +: WIDTH] = dob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      own_a_vld <= 1'b0;
      own_b_vld <= 1'b0;
      own_a_idx <= '0;
      own_b_idx <= '0;
    end else begin
      if (gnt_a) rr_ptr <= nxt_ptr;
      own_a_vld <= gnt_a;
      own_b_vld <= gnt_b;
      own_a_idx <= gnt_a ? a_idx : '0;
      own_b_idx <= gnt_b ? b_idx : '0;
    end
  end

`ifdef BRAM_ARB_STATS_EN
  logic [32:0] grants_sum;
  assign grants_sum = {1'b0, stat_grants} + 33'(gnt_a) + 33'(gnt_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants <= grants_sum[32] ? 32'hFFFF_FFFF : grants_sum[31:0];
      if (conflict && (stat_conflicts != 32'hFFFF_FFFF)) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_bram_tdp_arbiter.sv
// Directed bench for bram_tdp_arbiter: BRAM behavioural model, per-requester op queues,
// a list-based reference arbiter checked every cycle, plus literal spot checks.
module tb_bram_tdp_arbiter;
  localparam int NREQ  = 4;
  localparam int SIZE  = 1024;
  localparam int WIDTH = 32;
  localparam int AW    = 10;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_rdata;
  logic                  ena, enb, wea, web;
  logic [AW-1:0]         addra, addrb;
  logic [WIDTH-1:0]      dia, dib;
  logic [WIDTH-1:0]      doa = '0;
  logic [WIDTH-1:0]      dob = '0;
`ifdef BRAM_ARB_STATS_EN
  logic [31:0]           stat_grants, stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_tdp_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
    .doa(doa), .dob(dob)
`ifdef BRAM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  // Read-first registered BRAM attached to the arbiter's port pins.
  logic [WIDTH-1:0] ram [SIZE];
  always @(posedge clk) begin
    if (ena) begin
      doa <= ram[addra];
      if (wea) ram[addra] <= dia;
    end
    if (enb) begin
      dob <= ram[addrb];
      if (web) ram[addrb] <= dib;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Requester op queues and driver.
  logic             q_we   [NREQ][$];
  logic [AW-1:0]    q_addr [NREQ][$];
  logic [WIDTH-1:0] q_data [NREQ][$];
  logic [NREQ-1:0]  gnt_seen = '0;

  task automatic push_op(input int r, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    q_we[r].push_back(we);
    q_addr[r].push_back(a);
    q_data[r].push_back(d);
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_seen[r] && q_we[r].size() > 0) begin
        void'(q_we[r].pop_front());
        void'(q_addr[r].pop_front());
        void'(q_data[r].pop_front());
      end
      if (q_we[r].size() > 0) begin
        req_valid[r]                = 1'b1;
        req_we[r]                   = q_we[r][0];
        req_addr[r*AW +: AW]        = q_addr[r][0];
        req_wdata[r*WIDTH +: WIDTH] = q_data[r][0];
      end else begin
        req_valid[r]                = 1'b0;
        req_we[r]                   = 1'b0;
        req_addr[r*AW +: AW]        = '0;
        req_wdata[r*WIDTH +: WIDTH] = '0;
      end
    end
  endtask

  // Inputs change only just after the active edge so the model sees what the edge will sample.
  task automatic tick(input logic r);
    @(posedge clk);
    #1;
    rst = r;
    drive_reqs();
    @(negedge clk);
    #1;
  endtask

  // Reference model: memory image, rotation pointer, responses owed next cycle.
  logic [WIDTH-1:0] m_mem [SIZE];
  int               m_ptr = 0;
  logic [NREQ-1:0]  pend_v = '0;
  logic [WIDTH-1:0] pend_d [NREQ];
`ifdef BRAM_ARB_STATS_EN
  logic [31:0]      m_grants = '0;
  logic [31:0]      m_conf   = '0;
`endif

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input int i);
    return req_wdata[i*WIDTH +: WIDTH];
  endfunction

  always @(negedge clk) begin : compare
    int order[$];
    int a, b, c, ng;
    logic conf;
    logic [NREQ-1:0] e_ready, e_rv;
    logic [NREQ*WIDTH-1:0] e_rd;
    logic [AW+WIDTH+1:0] e_pa, e_pb;

    e_rv = '0;
    e_rd = '0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_v[i]) begin
          e_rv[i] = 1'b1;
          e_rd[i*WIDTH +: WIDTH] = pend_d[i];
        end
      end
    end

    // Valid requesters listed in priority order; A takes the head, B the first compatible follower.
    order.delete();
    a = -1;
    b = -1;
    conf = 1'b0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (req_valid[c]) order.push_back(c);
      end
      if (order.size() > 0) a = order[0];
      for (int j = 1; j < order.size(); j++) begin
        c = order[j];
        if (b < 0) begin
          if (addr_of(c) == addr_of(a) && (req_we[c] || req_we[a])) conf = 1'b1;
          else b = c;
        end
      end
    end

    e_ready = '0;
    e_pa = '0;
    e_pb = '0;
    if (a >= 0) begin
      e_ready[a] = 1'b1;
      e_pa = {1'b1, req_we[a], addr_of(a), data_of(a)};
    end
    if (b >= 0) begin
      e_ready[b] = 1'b1;
      e_pb = {1'b1, req_we[b], addr_of(b), data_of(b)};
    end

    chk("req_ready", 128'(req_ready), 128'(e_ready));
    chk("port_a", 128'({ena, wea, addra, dia}), 128'(e_pa));
    chk("port_b", 128'({enb, web, addrb, dib}), 128'(e_pb));
    chk("rsp_valid", 128'(rsp_valid), 128'(e_rv));
    chk("rsp_rdata", 128'(rsp_rdata), 128'(e_rd));
`ifdef BRAM_ARB_STATS_EN
    chk("stat_grants", 128'(stat_grants), 128'(m_grants));
    chk("stat_conflicts", 128'(stat_conflicts), 128'(m_conf));
`endif

    gnt_seen = req_ready & req_valid;

    pend_v = '0;
    ng = 0;
    if (rst) begin
      m_ptr = 0;
`ifdef BRAM_ARB_STATS_EN
      m_grants = '0;
      m_conf   = '0;
`endif
    end else begin
      if (a >= 0) begin pend_v[a] = 1'b1; pend_d[a] = m_mem[addr_of(a)]; ng++; end
      if (b >= 0) begin pend_v[b] = 1'b1; pend_d[b] = m_mem[addr_of(b)]; ng++; end
      if (a >= 0 && req_we[a]) m_mem[addr_of(a)] = data_of(a);
      if (b >= 0 && req_we[b]) m_mem[addr_of(b)] = data_of(b);
      if (a >= 0) m_ptr = (((b >= 0) ? b : a) + 1) % NREQ;
`ifdef BRAM_ARB_STATS_EN
      m_grants = m_grants + 32'(ng);
      if (conf) m_conf = m_conf + 32'd1;
`endif
    end
  end

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end

    tick(1'b1);
    tick(1'b1);
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));

    // Idle after reset.
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("idle_ports", 128'({ena, enb, wea, web}), 128'(0));
    chk("idle_rsp", 128'(rsp_valid), 128'(0));

    // Write then read from the same requester.
    push_op(0, 1'b1, 10'd5, 32'hDEAD_BEEF);
    push_op(0, 1'b0, 10'd5, 32'h0);
    tick(1'b0);
    chk("t2_wr_grant", 128'(req_ready), 128'(4'b0001));
    tick(1'b0);
    chk("t2_wr_rsp_v", 128'(rsp_valid), 128'(4'b0001));
    chk("t2_wr_rsp_old", 128'(rsp_rdata[31:0]), 128'(32'h0));
    tick(1'b0);
    chk("t2_rd_rsp", 128'(rsp_rdata[31:0]), 128'(32'hDEAD_BEEF));
    tick(1'b0);

    tick(1'b1);
    tick(1'b1);
    tick(1'b0);

    // Four continuous readers.
    for (int r = 0; r < NREQ; r++) begin
      push_op(r, 1'b0, 10'(r), 32'h0);
      push_op(r, 1'b0, 10'(r), 32'h0);
    end
    tick(1'b0);
    chk("t3_g01", 128'(req_ready), 128'(4'b0011));
    tick(1'b0);
    chk("t3_g23", 128'(req_ready), 128'(4'b1100));
    chk("t3_rsp01", 128'(rsp_valid), 128'(4'b0011));
    tick(1'b0);
    chk("t3_g01_again", 128'(req_ready), 128'(4'b0011));
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);

    // Write/read collision on one address.
    push_op(0, 1'b1, 10'd7, 32'h1234_5678);
    push_op(1, 1'b0, 10'd7, 32'h0);
    tick(1'b0);
    chk("t4_only_req0", 128'(req_ready), 128'(4'b0001));
    tick(1'b0);
    chk("t4_req1_next", 128'(req_ready), 128'(4'b0010));
`ifdef BRAM_ARB_STATS_EN
    chk("t4_stat_conf", 128'(stat_conflicts), 128'(32'd1));
`endif
    tick(1'b0);
    chk("t4_rd_new", 128'(rsp_rdata[63:32]), 128'(32'h1234_5678));

    // Two reads of the same address share a cycle.
    push_op(3, 1'b1, 10'd9, 32'hCAFE_F00D);
    tick(1'b0);
    chk("t5_wr_grant", 128'(req_ready), 128'(4'b1000));
    tick(1'b0);
    push_op(1, 1'b0, 10'd9, 32'h0);
    push_op(2, 1'b0, 10'd9, 32'h0);
    tick(1'b0);
    chk("t5_both", 128'(req_ready), 128'(4'b0110));
    tick(1'b0);
    chk("t5_rsp_v", 128'(rsp_valid), 128'(4'b0110));
    chk("t5_rsp_d", 128'(rsp_rdata[95:32]), 128'({32'hCAFE_F00D, 32'hCAFE_F00D}));

    // Reset while a read response is in flight.
    push_op(1, 1'b0, 10'd2, 32'h0);
    tick(1'b0);
    chk("t6_grant", 128'(req_ready), 128'(4'b0010));
    tick(1'b1);
    chk("t6_discard", 128'(rsp_valid), 128'(0));
    tick(1'b0);
    chk("t6_after_rst", 128'(rsp_valid), 128'(0));
    for (int r = 0; r < NREQ; r++) push_op(r, 1'b0, 10'(r), 32'h0);
    tick(1'b0);
    chk("t6_restart", 128'(req_ready), 128'(4'b0011));
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);

    chk("queues_drained", 128'(q_we[0].size() + q_we[1].size() + q_we[2].size() + q_we[3].size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
